packet_scheduler: RTL and testbench
===================================

PACKET_SCHEDULER -- requirements
Module: packet_scheduler

Interface
REQ-001 Parameter NUM_CH, default 6, number of channel buffers served (addr encodes 0..NUM_CH-1).
REQ-002 Parameter PKT_BYTES, default 1024, payload bytes per packet; legal range 2..65535.
REQ-003 clk  in  1  single clock; all logic SHALL be synchronous to its rising edge.
REQ-004 rstn  in  1  reset, asynchronous assert, active-low.
REQ-005 ch_enable  in  NUM_CH  per-channel enable mask; bit i = buffer i.
REQ-006 full_any  in  1  OR of buffer full flags; capture complete.
REQ-007 empty  in  NUM_CH  per-buffer empty flags (first-word-fall-through buffers).
REQ-008 axis_tready  in  1  downstream ready; also gates the header beat.
REQ-009 tx_done  in  1  one-cycle pulse: MAC finished transmitting the current frame.
REQ-010 rd_en  out  NUM_CH  one-hot buffer read request; ANDed with axis_tready externally.
REQ-011 addr  out  3  index of the channel whose byte drives the output mux.
REQ-012 axis_tvalid  out  1  payload byte valid.
REQ-013 axis_tlast  out  1  marks the last payload byte of the packet.
REQ-014 axis_tvalid_hdr  out  1  header request to the header builder.
REQ-015 busy  out  1  high whenever the state is not IDLE.
REQ-016 drained  out  1  one-cycle pulse when all enabled buffers are emptied.

Function
REQ-017 States SHALL be IDLE, SELECT, HDR, PAYLOAD, WAIT_DONE, with state, ptr, ch, and byte_cnt registered.
REQ-018 IDLE -> SELECT when full_any=1 and ch_enable!=0; otherwise remain in IDLE.
REQ-019 SELECT (1 cycle): search i = ptr, ptr+1, ... mod NUM_CH for the first i with ch_enable[i]=1 and empty[i]=0; if found, ch<=i, addr<=i, go to HDR.
REQ-020 SELECT with no qualifying channel -> IDLE, pulse drained=1 for that transition cycle, ptr<=0.
REQ-021 ch_enable SHALL be sampled only in SELECT; changes during HDR/PAYLOAD/WAIT_DONE have no effect on the current packet.
REQ-022 HDR: axis_tvalid_hdr=1, rd_en=0, axis_tvalid=0; advance to PAYLOAD on the first cycle with axis_tready=1, byte_cnt<=0.
REQ-023 PAYLOAD: axis_tvalid = rd_en[ch] = !empty[ch]; all other rd_en bits 0.
REQ-024 PAYLOAD with empty[ch]=1 SHALL stall (tvalid=0, byte_cnt unchanged) without error until data returns.
REQ-025 Transfer = axis_tvalid & axis_tready; each transfer increments byte_cnt by 1.
REQ-026 axis_tlast = axis_tvalid & (byte_cnt == PKT_BYTES-1), combinational from registered byte_cnt.
REQ-027 Transfer with axis_tlast=1 -> WAIT_DONE, byte_cnt<=0; exactly PKT_BYTES transfers per packet.
REQ-028 WAIT_DONE: all stream outputs 0; on tx_done=1 set ptr<=(ch+1) mod NUM_CH and go to SELECT.
REQ-029 tx_done in any state other than WAIT_DONE SHALL be ignored.
REQ-030 A tx_done in the same cycle as the tlast transfer SHALL be ignored; only pulses in WAIT_DONE count.
REQ-031 addr SHALL hold its value outside SELECT, so the mux stays stable through WAIT_DONE.
REQ-032 full_any is used only in IDLE; it is ignored once busy.
REQ-033 busy = (state != IDLE).

Reset
REQ-034 rstn=0 SHALL asynchronously force state=IDLE, ptr=0, ch=0, addr=0, and byte_cnt=0.
REQ-035 rstn=0 SHALL asynchronously force rd_en, axis_tvalid, axis_tlast, axis_tvalid_hdr, busy, and drained to 0.
REQ-036 Reset mid-packet SHALL abandon the packet; after rstn deasserts, the block waits in IDLE for full_any.

Verification
REQ-037 ch_enable=6'h3F, all non-empty, full_any pulse, tready=1, PKT_BYTES=4 -> packets in order addr 0,1,2,3,4,5.
REQ-038 Same as REQ-037, each packet -> one hdr cycle, 4 tvalid beats, tlast on beat 4, then a wait for tx_done.
REQ-039 ch_enable=6'b100101, all non-empty -> addr sequence 0,2,5, then 0 again only while a buffer is still non-empty.
REQ-040 Buffer 2 empty in SELECT -> channel 2 skipped; all enabled buffers empty -> drained pulses once, state IDLE, busy=0.
REQ-041 In PAYLOAD, tready low 3 cycles and empty[ch] high 2 cycles -> byte_cnt frozen, tvalid and rd_en follow !empty, tlast still on the 4th transfer only.
REQ-042 tx_done pulse during PAYLOAD -> ignored, packet completes; rstn low in the middle of a packet -> all outputs 0 the same cycle, restart from addr 0.

Source files
------------

// File: rtl/packet_scheduler_if.sv
// rtl/packet_scheduler_if.sv - channel-buffer, stream and status signals of the packet scheduler
interface packet_scheduler_if #(
    parameter int NUM_CH = 6
);
    logic [NUM_CH-1:0] ch_enable;
    logic              full_any;
    logic [NUM_CH-1:0] empty;
    logic              axis_tready;
    logic              tx_done;
    logic [NUM_CH-1:0] rd_en;
    logic [2:0]        addr;
    logic              axis_tvalid;
    logic              axis_tlast;
    logic              axis_tvalid_hdr;
    logic              busy;
    logic              drained;

    modport master (
        input  ch_enable, full_any, empty, axis_tready, tx_done,
        output rd_en, addr, axis_tvalid, axis_tlast, axis_tvalid_hdr, busy, drained
    );

    modport slave (
        output ch_enable, full_any, empty, axis_tready, tx_done,
        input  rd_en, addr, axis_tvalid, axis_tlast, axis_tvalid_hdr, busy, drained
    );
endinterface

// File: rtl/packet_scheduler.sv
// rtl/packet_scheduler.sv - round-robin drain of channel buffers into header + fixed-length payload packets
module packet_scheduler #(
    parameter int NUM_CH    = 6,
    parameter int PKT_BYTES = 1024
) (
    input  logic               clk,
    input  logic               rstn,
    packet_scheduler_if.master bus
);
    typedef enum logic [2:0] {IDLE, SELECT, HDR, PAYLOAD, WAIT_DONE} state_t;

    localparam logic [15:0] LAST_BYTE = 16'(PKT_BYTES - 1);
    localparam logic [2:0]  LAST_CH   = 3'(NUM_CH - 1);

    state_t      state, state_next;
    logic [2:0]  ptr, ptr_next;
    logic [2:0]  ch, ch_next;
    logic [2:0]  addr_q, addr_next;
    logic [15:0] byte_cnt, byte_cnt_next;

    logic              found;
    logic [2:0]        found_idx;
    int                idx;
    logic [2:0]        idx3;
    logic [NUM_CH-1:0] rd_en_c;
    logic              tvalid_c, tlast_c, hdr_c, drained_c;

    // Round-robin search starting at ptr, wrapping at NUM_CH.
    always_comb begin
        found     = 1'b0;
        found_idx = '0;
        idx       = 0;
        idx3      = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_CH) idx = idx - NUM_CH;
            idx3 = idx[2:0];
            if (!found && bus.ch_enable[idx3] && !bus.empty[idx3]) begin
                found     = 1'b1;
                found_idx = idx3;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= IDLE;
            ptr      <= '0;
            ch       <= '0;
            addr_q   <= '0;
            byte_cnt <= '0;
        end else begin
            state    <= state_next;
            ptr      <= ptr_next;
            ch       <= ch_next;
            addr_q   <= addr_next;
            byte_cnt <= byte_cnt_next;
        end
    end

    always_comb begin
        state_next    = state;
        ptr_next      = ptr;
        ch_next       = ch;
        addr_next     = addr_q;
        byte_cnt_next = byte_cnt;
        rd_en_c       = '0;
        tvalid_c      = 1'b0;
        tlast_c       = 1'b0;
        hdr_c         = 1'b0;
        drained_c     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.full_any && (|bus.ch_enable)) state_next = SELECT;
            end
            SELECT: begin
                if (found) begin
                    ch_next    = found_idx;
                    addr_next  = found_idx;
                    state_next = HDR;
                end else begin
                    drained_c  = 1'b1;
                    ptr_next   = '0;
                    state_next = IDLE;
                end
            end
            HDR: begin
                hdr_c = 1'b1;
                if (bus.axis_tready) begin
                    byte_cnt_next = '0;
                    state_next    = PAYLOAD;
                end
            end
            PAYLOAD: begin
                // An empty buffer simply stalls the beat; byte_cnt holds.
                tvalid_c    = !bus.empty[ch];
                rd_en_c[ch] = tvalid_c;
                tlast_c     = tvalid_c && (byte_cnt == LAST_BYTE);
                if (tvalid_c && bus.axis_tready) begin
                    if (tlast_c) begin
                        byte_cnt_next = '0;
                        state_next    = WAIT_DONE;
                    end else begin
                        byte_cnt_next = byte_cnt + 16'd1;
                    end
                end
            end
            WAIT_DONE: begin
                if (bus.tx_done) begin
                    ptr_next   = (ch == LAST_CH) ? 3'd0 : ch + 3'd1;
                    state_next = SELECT;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign bus.rd_en           = rd_en_c;
    assign bus.addr            = addr_q;
    assign bus.axis_tvalid     = tvalid_c;
    assign bus.axis_tlast      = tlast_c;
    assign bus.axis_tvalid_hdr = hdr_c;
    assign bus.busy            = (state != IDLE);
    assign bus.drained         = drained_c;
endmodule

// File: tb/tb_packet_scheduler.sv
// tb/tb_packet_scheduler.sv - directed self-checking bench for packet_scheduler (NUM_CH=6, PKT_BYTES=4)
module tb_packet_scheduler;
    logic clk;
    logic rstn;
    int   checks = 0;
    int   errors = 0;

    packet_scheduler_if #(.NUM_CH(6)) bus ();

    packet_scheduler #(.NUM_CH(6), .PKT_BYTES(4)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Entered while in SELECT with channel a qualifying; leaves the DUT in the next SELECT.
    task automatic expect_packet(input logic [2:0] a, input logic [5:0] next_empty);
        logic [5:0] oh;
        oh = 6'd1 << a;
        check("sel_busy", 32'(bus.busy), 1);
        check("sel_hdr", 32'(bus.axis_tvalid_hdr), 0);
        check("sel_tvalid", 32'(bus.axis_tvalid), 0);
        tick();
        check("hdr_req", 32'(bus.axis_tvalid_hdr), 1);
        check("hdr_addr", 32'(bus.addr), 32'(a));
        check("hdr_rd_en", 32'(bus.rd_en), 0);
        check("hdr_tvalid", 32'(bus.axis_tvalid), 0);
        tick();
        for (int i = 0; i < 4; i++) begin
            check("pay_tvalid", 32'(bus.axis_tvalid), 1);
            check("pay_rd_en", 32'(bus.rd_en), 32'(oh));
            check("pay_tlast", 32'(bus.axis_tlast), (i == 3) ? 1 : 0);
            check("pay_addr", 32'(bus.addr), 32'(a));
            tick();
        end
        check("wait_tvalid", 32'(bus.axis_tvalid), 0);
        check("wait_tlast", 32'(bus.axis_tlast), 0);
        check("wait_hdr", 32'(bus.axis_tvalid_hdr), 0);
        check("wait_rd_en", 32'(bus.rd_en), 0);
        check("wait_busy", 32'(bus.busy), 1);
        bus.empty = next_empty;
        tick();
        check("wait_hold_busy", 32'(bus.busy), 1);
        check("wait_hold_addr", 32'(bus.addr), 32'(a));
        bus.tx_done = 1'b1;
        tick();
        bus.tx_done = 1'b0;
    endtask

    task automatic expect_drain();
        check("drain_pulse", 32'(bus.drained), 1);
        tick();
        check("drain_idle_busy", 32'(bus.busy), 0);
        check("drain_once", 32'(bus.drained), 0);
    endtask

    bit tr_v [9] = '{1, 0, 0, 1, 1, 1, 1, 0, 1};
    bit e_v  [9] = '{0, 0, 0, 1, 1, 0, 0, 0, 0};
    bit td_v [9] = '{0, 0, 1, 0, 0, 0, 0, 0, 1};
    bit tv_x [9] = '{1, 1, 1, 0, 0, 1, 1, 1, 1};
    bit tl_x [9] = '{0, 0, 0, 0, 0, 0, 0, 1, 1};

    initial begin
        rstn            = 1'b0;
        bus.ch_enable   = '0;
        bus.full_any    = 1'b0;
        bus.empty       = '1;
        bus.axis_tready = 1'b1;
        bus.tx_done     = 1'b0;
        tick();
        tick();
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_addr", 32'(bus.addr), 0);
        check("rst_rd_en", 32'(bus.rd_en), 0);
        check("rst_tvalid", 32'(bus.axis_tvalid), 0);
        check("rst_hdr", 32'(bus.axis_tvalid_hdr), 0);
        check("rst_drained", 32'(bus.drained), 0);
        rstn = 1'b1;

        // full_any with no channel enabled keeps the block idle
        bus.full_any = 1'b1;
        tick();
        check("idle_no_enable", 32'(bus.busy), 0);

        // All six channels served in order
        bus.ch_enable = 6'h3F;
        bus.empty     = 6'h00;
        tick();
        bus.full_any = 1'b0;
        for (int c = 0; c < 5; c++) expect_packet(3'(c), 6'h00);
        expect_packet(3'd5, 6'h3F);
        expect_drain();

        // Sparse mask, then channel 2 empty gets skipped
        bus.ch_enable = 6'b100101;
        bus.empty     = 6'h00;
        bus.full_any  = 1'b1;
        tick();
        bus.full_any = 1'b0;
        expect_packet(3'd0, 6'h00);
        expect_packet(3'd2, 6'h00);
        expect_packet(3'd5, 6'h00);
        expect_packet(3'd0, 6'b000100);
        expect_packet(3'd5, 6'h3F);
        expect_drain();

        // Stalls from tready and empty, tx_done outside WAIT_DONE ignored
        bus.ch_enable = 6'b000010;
        bus.empty     = 6'h00;
        bus.full_any  = 1'b1;
        tick();
        bus.full_any    = 1'b0;
        bus.axis_tready = 1'b0;
        tick();
        check("hdr_stall_req", 32'(bus.axis_tvalid_hdr), 1);
        tick();
        check("hdr_stall_hold", 32'(bus.axis_tvalid_hdr), 1);
        check("hdr_stall_addr", 32'(bus.addr), 1);
        bus.axis_tready = 1'b1;
        tick();
        for (int i = 0; i < 9; i++) begin
            bus.axis_tready = tr_v[i];
            bus.empty       = e_v[i] ? 6'b000010 : 6'b000000;
            bus.tx_done     = td_v[i];
            #1;
            check("stall_tvalid", 32'(bus.axis_tvalid), 32'(tv_x[i]));
            check("stall_rd_en", 32'(bus.rd_en), tv_x[i] ? 2 : 0);
            check("stall_tlast", 32'(bus.axis_tlast), 32'(tl_x[i]));
            tick();
        end
        bus.tx_done     = 1'b0;
        bus.axis_tready = 1'b1;
        bus.empty       = 6'h3F;
        #1;
        check("late_wait_tvalid", 32'(bus.axis_tvalid), 0);
        check("late_wait_busy", 32'(bus.busy), 1);
        tick();
        check("tlast_txdone_ignored", 32'(bus.busy), 1);
        check("tlast_txdone_tvalid", 32'(bus.axis_tvalid), 0);
        bus.tx_done = 1'b1;
        tick();
        bus.tx_done = 1'b0;
        expect_drain();

        // Reset in the middle of a packet
        bus.ch_enable = 6'b001000;
        bus.empty     = 6'h00;
        bus.full_any  = 1'b1;
        tick();
        bus.full_any = 1'b0;
        tick();
        check("mid_hdr_addr", 32'(bus.addr), 3);
        tick();
        tick();
        check("mid_pay_tvalid", 32'(bus.axis_tvalid), 1);
        rstn = 1'b0;
        #1;
        check("async_rst_tvalid", 32'(bus.axis_tvalid), 0);
        check("async_rst_rd_en", 32'(bus.rd_en), 0);
        check("async_rst_busy", 32'(bus.busy), 0);
        check("async_rst_addr", 32'(bus.addr), 0);
        check("async_rst_tlast", 32'(bus.axis_tlast), 0);
        tick();
        rstn          = 1'b1;
        bus.ch_enable = 6'h3F;
        tick();
        tick();
        check("post_rst_idle", 32'(bus.busy), 0);
        bus.full_any = 1'b1;
        tick();
        bus.full_any = 1'b0;
        expect_packet(3'd0, 6'h3F);
        expect_drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
